// File: rtl/ppu_pkg.sv
// ------------------------------------------------------------------
// ppu_pkg : shared state encoding and fixed-point constants for the
//           posit reciprocal refinement datapath.  Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package ppu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MUL_XY = 2'd1,
    MUL_YT = 2'd2,
    DONE   = 2'd3
  } nr_state_e;

  // 2.0 in Q2.(3N-2); caller slices the low 3N bits.
  function automatic logic [255:0] two_q2(input int n);
    return 256'(1) << (3 * n - 1);
  endfunction

  // All-ones saturation value for a 2N-bit reciprocal; caller slices the low 2N bits.
  function automatic logic [255:0] sat_ones(input int n);
    return (256'(1) << (2 * n)) - 256'(1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/nr_mul.sv
// ------------------------------------------------------------------
// nr_mul : unsigned W x W -> 2W combinational multiplier, kept on its
//          own so it can be pipelined or mapped to a DSP later.  Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module nr_mul #(
  parameter int W = 32
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] p
);

  assign p = {{W{1'b0}}, a} * {{W{1'b0}}, b};

endmodule

`default_nettype wire

// File: rtl/newton_raphson_refine.sv
// ------------------------------------------------------------------
// newton_raphson_refine : refines a 3N-bit reciprocal seed with ITERS
//                         Newton-Raphson steps on one shared multiplier.  Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module newton_raphson_refine
  import ppu_pkg::*;
#(
  parameter int N     = 16,
  parameter int ITERS = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_valid,
  output logic           o_ready,
  input  logic [N-1:0]   i_x,
  input  logic [3*N-1:0] i_y0,
  output logic           o_valid,
  input  logic           i_ready,
  output logic [2*N-1:0] o_recip,
  output logic           o_err
);

  localparam int W  = 2 * N;
  localparam int PW = 4 * N;
  localparam logic [255:0] TWO_FULL = two_q2(N);
  localparam logic [255:0] SAT_FULL = sat_ones(N);
  localparam logic [3*N-1:0] TWO_Q2   = TWO_FULL[3*N-1:0];
  localparam logic [W-1:0]   SAT_ONES = SAT_FULL[W-1:0];
  localparam logic [2:0]     ITERS_C  = 3'(ITERS);

  nr_state_e      state_q, state_d;
  logic [N-1:0]   x_q, x_d;
  logic [W-1:0]   y_q, y_d;
  logic [W-1:0]   t_q, t_d;
  logic [2:0]     cnt_q, cnt_d;
  logic           err_q, err_d;

  logic [W-1:0]   mul_a, mul_b;
  logic [PW-1:0]  mul_p;
  logic [3*N-1:0] t_full;
  logic           sat;
  logic           unused_bits;

  // Operand mux: the only arithmetic resource is shared between both half-steps.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state_q)
      MUL_XY: begin
        mul_a = {{N{1'b0}}, x_q};
        mul_b = y_q;
      end
      MUL_YT: begin
        mul_a = y_q;
        mul_b = t_q;
      end
      default: ;
    endcase
  end

  nr_mul #(.W(W)) u_mul (
    .a (mul_a),
    .b (mul_b),
    .p (mul_p)
  );

  // 2 - x*y in Q2.(3N-2), wrapping modulo 2^3N.
  assign t_full = TWO_Q2 - mul_p[3*N-1:0];
  assign sat    = mul_p[PW-1] | mul_p[PW-2];

  assign unused_bits = ^{i_y0[N-1:0], t_full[N-1:0]};

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    t_d     = t_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          x_d   = i_x;
          cnt_d = '0;
          err_d = ~i_x[N-1];
          if (!i_x[N-1]) begin
            y_d     = '0;
            state_d = DONE;
          end else begin
            y_d     = i_y0[3*N-1 -: W];
            state_d = (ITERS == 0) ? DONE : MUL_XY;
          end
        end
      end
      MUL_XY: begin
        t_d     = t_full[3*N-1 -: W];
        state_d = MUL_YT;
      end
      MUL_YT: begin
        y_d     = sat ? SAT_ONES : mul_p[PW-3 -: W];
        cnt_d   = cnt_q + 3'd1;
        state_d = ((cnt_q + 3'd1) < ITERS_C) ? MUL_XY : DONE;
      end
      DONE: begin
        if (i_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      t_q     <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      t_q     <= t_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign o_ready = (state_q == IDLE);
  assign o_valid = (state_q == DONE);
  assign o_recip = y_q;
  assign o_err   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_newton_raphson_refine.sv
// ------------------------------------------------------------------
// tb_newton_raphson_refine : directed bench with an arithmetic reference
//                            model and a per-cycle handshake checker.  Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_newton_raphson_refine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        i_valid, o_ready, o_valid, i_ready, o_err;
  logic [15:0] i_x;
  logic [47:0] i_y0;
  logic [31:0] o_recip;

  logic        i_valid_b, o_ready_b, o_valid_b, i_ready_b, o_err_b;
  logic [15:0] i_x_b;
  logic [47:0] i_y0_b;
  logic [31:0] o_recip_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  newton_raphson_refine #(.N(16), .ITERS(2)) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_x(i_x), .i_y0(i_y0), .o_valid(o_valid), .i_ready(i_ready),
    .o_recip(o_recip), .o_err(o_err)
  );

  newton_raphson_refine #(.N(16), .ITERS(0)) dut_bypass (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid_b), .o_ready(o_ready_b),
    .i_x(i_x_b), .i_y0(i_y0_b), .o_valid(o_valid_b), .i_ready(i_ready_b),
    .o_recip(o_recip_b), .o_err(o_err_b)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_tol(input string name, input logic [31:0] act, input logic [31:0] gold, input int tol);
    logic [31:0] diff;
    diff = (act > gold) ? act - gold : gold - act;
    n_checks++;
    if (diff > 32'(tol)) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h +/- %0d", name, act, gold, tol);
    end
  endtask

  // Plain-integer statement of one refinement: y <- y*(2 - x*y) in the
  // stated fixed-point formats, with saturation when y*t reaches 2.0.
  function automatic void model(input logic [15:0] x, input logic [47:0] y0, input int iters,
                                output logic [31:0] r, output logic e);
    logic [63:0] y, p, t, prod;
    if (x < 16'h8000) begin
      r = '0;
      e = 1'b1;
      return;
    end
    e = 1'b0;
    y = {16'h0, y0} / 64'h1_0000;
    for (int i = 0; i < iters; i++) begin
      p    = ({48'h0, x} * y) % 64'h1_0000_0000_0000;
      t    = ((64'h1_0000_0000_0000 + 64'h8000_0000_0000 - p) % 64'h1_0000_0000_0000) / 64'h1_0000;
      prod = y * t;
      if (prod >= 64'h4000_0000_0000_0000) y = 64'hFFFF_FFFF;
      else                                 y = prod / 64'h4000_0000;
    end
    r = y[31:0];
  endfunction

  // Coarse seed: 1/x in Q1.47 keeping only the top 12 bits.
  function automatic logic [47:0] seed(input logic [15:0] x);
    logic [63:0] q;
    q = 64'h4000_0000_0000_0000 / {48'h0, x};
    return q[47:0] & 48'hFFF0_0000_0000;
  endfunction

  function automatic logic [31:0] golden(input logic [15:0] x);
    logic [63:0] g;
    g = (64'h4000_0000_0000 + {48'h0, x} / 2) / {48'h0, x};
    return g[31:0];
  endfunction

  // Per-cycle checker for the ITERS=2 instance.
  bit          pend = 1'b0;
  int          cyc = 0;
  int          exp_lat = 0;
  logic [31:0] exp_r;
  logic        exp_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      pend = 1'b0;
      check("rst_valid", 64'(o_valid), 64'd0);
      check("rst_ready", 64'(o_ready), 64'd1);
    end else begin
      if (pend) cyc++;
      if (!pend) begin
        check("idle_ready", 64'(o_ready), 64'd1);
        check("idle_valid", 64'(o_valid), 64'd0);
      end else if (cyc < exp_lat) begin
        check("busy_ready", 64'(o_ready), 64'd0);
        check("busy_valid", 64'(o_valid), 64'd0);
      end else begin
        check("done_valid", 64'(o_valid), 64'd1);
        check("done_ready", 64'(o_ready), 64'd0);
        check("done_recip", 64'(o_recip), 64'(exp_r));
        check("done_err",   64'(o_err),   64'(exp_e));
      end
      if (!pend && i_valid) begin
        pend = 1'b1;
        cyc  = 0;
        model(i_x, i_y0, 2, exp_r, exp_e);
        exp_lat = exp_e ? 1 : 5;
      end else if (pend && cyc >= exp_lat && i_ready) begin
        pend = 1'b0;
      end
    end
  end

  task automatic run_op(input logic [15:0] x, input logic [47:0] y0, input int hold, input bit noise,
                        output logic [31:0] r, output logic e, output int lat);
    int k;
    k = 0;
    while (!o_ready && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    if (!o_ready) check("ready_timeout", 64'(o_ready), 64'd1);
    i_x = x;
    i_y0 = y0;
    i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = noise;
    if (noise) begin
      i_x  = 16'hFFFF;
      i_y0 = 48'h1234_5678_9ABC;
    end
    lat = 1;
    while (!o_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!o_valid) check("valid_timeout", 64'(o_valid), 64'd1);
    i_valid = 1'b0;
    r = o_recip;
    e = o_err;
    repeat (hold) begin
      @(posedge clk); #1;
    end
    i_ready = 1'b1;
    @(posedge clk); #1;
    i_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    logic        e;
    int          lat;
    i_valid = 0; i_ready = 0; i_x = '0; i_y0 = '0;
    i_valid_b = 0; i_ready_b = 0; i_x_b = '0; i_y0_b = '0;

    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", 64'(o_ready), 64'd1);
    check("reset_valid", 64'(o_valid), 64'd0);
    check("reset_recip", 64'(o_recip), 64'd0);
    check("reset_err",   64'(o_err),   64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(16'h8000, 48'h8000_0000_0000, 0, 0, r, e, lat);
    check("identity_recip", 64'(r), 64'h8000_0000);
    check("identity_err",   64'(e), 64'd0);
    check("identity_lat",   64'(lat), 64'd5);

    run_op(16'hC000, seed(16'hC000), 0, 0, r, e, lat);
    check_tol("conv_c000", r, 32'h5555_5555, 2);

    run_op(16'h4000, 48'h8000_0000_0000, 0, 0, r, e, lat);
    check("error_recip", 64'(r), 64'd0);
    check("error_err",   64'(e), 64'd1);
    check("error_lat",   64'(lat), 64'd1);

    // Backpressure plus operands presented while busy.
    run_op(16'hA000, seed(16'hA000), 10, 1, r, e, lat);
    check_tol("bp_a000", r, 32'h6666_6666, 4);
    check("bp_err_cleared", 64'(e), 64'd0);

    run_op(16'h8000, 48'h8000_0000_0000, 3, 1, r, e, lat);
    check("busy_ignore_recip", 64'(r), 64'h8000_0000);

    // x~2, y~2: t wraps to ~2.0, y*t >= 2 every step, so the output pins at all ones.
    run_op(16'hFFFF, 48'hFFFF_FFFF_FFFF, 0, 0, r, e, lat);
    check("sat_ffff_recip", 64'(r), 64'hFFFF_FFFF);
    // x=1, y~2: 2 - x*y = 2^-31 truncates to zero in Q2.30, collapsing y to 0.
    run_op(16'h8000, 48'hFFFF_FFFF_FFFF, 0, 0, r, e, lat);
    check("sat_8000_recip", 64'(r), 64'h0);

    // Reset while the second half-step is in flight.
    i_x = 16'hC000; i_y0 = seed(16'hC000); i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 64'(o_valid), 64'd0);
    check("midrst_ready", 64'(o_ready), 64'd1);
    check("midrst_recip", 64'(o_recip), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_op(16'h8000, 48'h8000_0000_0000, 0, 0, r, e, lat);
    check("post_rst_recip", 64'(r), 64'h8000_0000);
    check("post_rst_lat",   64'(lat), 64'd5);

    // ITERS=0 instance returns the truncated seed one cycle after accept.
    i_x_b = 16'h9000; i_y0_b = 48'hAAAA_BBBB_CCCC; i_valid_b = 1'b1;
    @(posedge clk); #1;
    i_valid_b = 1'b0;
    check("bypass_valid", 64'(o_valid_b), 64'd1);
    check("bypass_recip", 64'(o_recip_b), 64'hAAAA_BBBB);
    check("bypass_err",   64'(o_err_b),   64'd0);
    i_ready_b = 1'b1;
    @(posedge clk); #1;
    i_ready_b = 1'b0;
    check("bypass_ready_after_pop", 64'(o_ready_b), 64'd1);

    for (int x = 32'h8000; x <= 32'hFFFF; x += 257) begin
      run_op(16'(x), seed(16'(x)), 0, 0, r, e, lat);
      check_tol("sweep", r, golden(16'(x)), 4);
    end
    run_op(16'hFFFF, seed(16'hFFFF), 0, 0, r, e, lat);
    check_tol("sweep_ffff", r, golden(16'hFFFF), 4);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
